// File: rtl/wdt_pkg.sv
// Shared types and sizing helper for the watchdog reset controller.
package wdt_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RESET   = 2'd2
    } wdt_state_e;

    // Sticky reset cause, encoded exactly as software reads it back.
    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_ACK_TO = 2'b01,
        CAUSE_STRIKE = 2'b10
    } wdt_cause_e;

    // Bits needed to hold an unsigned value up to load_val (at least 1).
    function automatic int cnt_width(input int load_val);
        return (load_val < 1) ? 1 : $clog2(load_val + 1);
    endfunction

endpackage

// File: rtl/wdt_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module wdt_down_counter
    import wdt_pkg::*;
#(
    parameter int MAX_VAL = 15,
    localparam int W = cnt_width(MAX_VAL)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority; enabled decrements stop at zero instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/wdt_reset_controller.sv
// Turns watchdog timeouts into an acknowledged CPU interrupt and escalates to a
// stretched active-low system reset on ack timeout or strike limit.
module wdt_reset_controller
    import wdt_pkg::*;
#(
    parameter int MAX_STRIKES   = 3,
    parameter int ACK_WINDOW    = 64,
    parameter int RST_PULSE_LEN = 16,
    localparam int SW = $clog2(MAX_STRIKES + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wdt_intr,
    input  logic          ack,
    input  logic          clr_cause,
    output logic          irq_out,
    output logic          sys_rstn_out,
    output logic [SW-1:0] strike_cnt,
    output logic [1:0]    reset_cause
);

    localparam int WIN_MAX = ACK_WINDOW - 1;
    localparam int PUL_MAX = RST_PULSE_LEN - 1;
    localparam int WIN_W   = cnt_width(WIN_MAX);
    localparam int PUL_W   = cnt_width(PUL_MAX);

    localparam logic [WIN_W-1:0] WIN_LOAD   = WIN_W'(WIN_MAX);
    localparam logic [PUL_W-1:0] PUL_LOAD   = PUL_W'(PUL_MAX);
    localparam logic [SW-1:0]    STRIKE_MAX = SW'(MAX_STRIKES);

    wdt_state_e    state, state_d;
    wdt_cause_e    cause_q, cause_d;
    logic          wdt_intr_q;
    logic          tmo_edge;
    logic [SW-1:0] strike_d, strike_base, strike_inc;
    logic          irq_d, rstn_d;
    logic          win_load, win_zero;
    logic          pul_load, pul_zero;

    // A timeout is the rising edge of the watchdog level; a level high at reset
    // release counts because wdt_intr_q comes out of reset low.
    assign tmo_edge = wdt_intr & ~wdt_intr_q;

    // clr_cause in the same cycle as an edge counts that edge from zero.
    assign strike_base = clr_cause ? '0 : strike_cnt;
    assign strike_inc  = (strike_base == STRIKE_MAX) ? strike_base : strike_base + 1'b1;

    assign reset_cause = cause_q;

    // Acknowledge window: runs only while PENDING.
    wdt_down_counter #(.MAX_VAL(WIN_MAX)) u_win_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (win_load),
        .load_val (WIN_LOAD),
        .en       (state == PENDING),
        .zero     (win_zero)
    );

    // Reset pulse stretcher: runs only while in RESET.
    wdt_down_counter #(.MAX_VAL(PUL_MAX)) u_pul_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (pul_load),
        .load_val (PUL_LOAD),
        .en       (state == RESET),
        .zero     (pul_zero)
    );

    // State register plus edge-detect history (history keeps tracking in RESET).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            wdt_intr_q <= 1'b0;
        end else begin
            state      <= state_d;
            wdt_intr_q <= wdt_intr;
        end
    end

    // Registered outputs so every response lands one clock after its cause.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_out      <= 1'b0;
            sys_rstn_out <= 1'b1;
            strike_cnt   <= '0;
            cause_q      <= CAUSE_NONE;
        end else begin
            irq_out      <= irq_d;
            sys_rstn_out <= rstn_d;
            strike_cnt   <= strike_d;
            cause_q      <= cause_d;
        end
    end

    // Next state and outputs; priority in PENDING is strike limit, ack, expiry.
    always_comb begin
        state_d  = state;
        irq_d    = irq_out;
        rstn_d   = sys_rstn_out;
        strike_d = strike_cnt;
        cause_d  = cause_q;
        win_load = 1'b0;
        pul_load = 1'b0;

        case (state)
            IDLE, PENDING: begin
                strike_d = tmo_edge ? strike_inc : strike_base;
                if (clr_cause)
                    cause_d = CAUSE_NONE;

                if (tmo_edge && (strike_inc == STRIKE_MAX)) begin
                    state_d  = RESET;
                    cause_d  = CAUSE_STRIKE;
                    irq_d    = 1'b0;
                    rstn_d   = 1'b0;
                    pul_load = 1'b1;
                end else if (state == PENDING) begin
                    // A non-limit edge here is counted but does not restart the window.
                    if (ack) begin
                        state_d = IDLE;
                        irq_d   = 1'b0;
                    end else if (win_zero) begin
                        state_d  = RESET;
                        cause_d  = CAUSE_ACK_TO;
                        irq_d    = 1'b0;
                        rstn_d   = 1'b0;
                        pul_load = 1'b1;
                    end
                end else if (tmo_edge) begin
                    state_d  = PENDING;
                    irq_d    = 1'b1;
                    win_load = 1'b1;
                end
            end

            RESET: begin
                // Edges, ack and clr_cause are all ignored until the pulse ends.
                irq_d  = 1'b0;
                rstn_d = 1'b0;
                if (pul_zero) begin
                    state_d  = IDLE;
                    rstn_d   = 1'b1;
                    strike_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
                rstn_d  = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/wdt_reset_controller.md
Name: wdt_reset_controller

Overview:
- Sits directly downstream of the watchdog top level and consumes its interrupt output.
- Converts watchdog timeouts into a CPU interrupt with an acknowledge handshake.
- Escalates to a stretched, active-low system reset pulse when the acknowledge window expires or repeated timeouts reach a strike limit.
- Records a sticky reset cause for software readback after the reset.

Parameters:
- MAX_STRIKES, 3, number of timeout edges that forces a system reset; legal range 1..15.
- ACK_WINDOW, 64, cycles allowed for acknowledge after irq_out asserts; legal range ≥ 2.
- RST_PULSE_LEN, 16, cycles sys_rstn_out is held low; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rstn  input  1  asynchronous active-low reset.
- wdt_intr  input  1  level interrupt from the watchdog top level.
- ack  input  1  single-cycle CPU acknowledge pulse.
- clr_cause  input  1  clears the reset_cause and strike_cnt outputs.
- irq_out  output  1  interrupt to the CPU.
- sys_rstn_out  output  1  active-low system reset request.
- strike_cnt  output  $clog2(MAX_STRIKES+1)  timeout edges counted since the last clear.
- reset_cause  output  2  00 none, 01 acknowledge timeout, 10 strike limit; sticky.

Behaviour:
- Reset values (rstn low, asynchronous): irq_out=0, sys_rstn_out=1, strike_cnt=0, reset_cause=00, state=IDLE, wdt_intr_q=0, counters=0.
- Edge detect: a timeout edge is wdt_intr=1 with registered wdt_intr_q=0. A level held high counts once. A high level at reset release counts as an edge on the first clock.
- All outputs are registered. The response appears after the clock edge that samples the event (latency 1).
- State IDLE:
  - Timeout edge: strike_cnt+1.
  - If the new count equals MAX_STRIKES, go to RESET with cause=10.
  - Otherwise go to PENDING, set irq_out=1, and load the window counter with ACK_WINDOW-1.
- State PENDING: irq_out=1; the window counter decrements each cycle.
  - ack: go to IDLE and clear irq_out. strike_cnt is retained.
  - Window counter at 0 with no ack: go to RESET with cause=01.
  - New timeout edge: strike_cnt+1. If it reaches MAX_STRIKES, go to RESET with cause=10. This edge does not restart the window.
  - Priority: strike limit, then ack, then window expiry.
  - ack and a non-limit edge in the same cycle: the edge is counted and the block goes to IDLE.
  - ack and expiry in the same cycle: ack wins.
- State RESET:
  - irq_out=0, sys_rstn_out=0 for exactly RST_PULSE_LEN cycles, then sys_rstn_out=1 and go to IDLE.
  - strike_cnt clears on exit.
  - Timeout edges and ack are ignored while in RESET, but wdt_intr_q keeps tracking the input.
- reset_cause:
  - Written only on entry to RESET.
  - Holds through RESET and IDLE until clr_cause or rstn.
  - A later escalation overwrites it.
- clr_cause clears reset_cause and strike_cnt in any state except RESET, where it is ignored.
- sys_rstn_out does not reset this block. Only rstn does.
- Arithmetic: strike_cnt never exceeds MAX_STRIKES. Counters are unsigned, sized $clog2 of their load value plus 1, and never underflow.
- Assertion rules for the verification bench:
  - sys_rstn_out and irq_out are never both active.
  - sys_rstn_out low implies state=RESET.

Decomposition:
- Package wdt_pkg holds:
  - the state enum typedef (IDLE, PENDING, RESET);
  - the cause enum typedef (CAUSE_NONE, CAUSE_ACK_TO, CAUSE_STRIKE);
  - the shared counter-width function.
- Sub-module wdt_down_counter: loadable down-counter with load, enable and zero flag. Instantiated twice, once for the acknowledge window and once for the reset pulse.
- The FSM and edge detect stay in the top module.

Test Plan:
- Pulse wdt_intr high for 5 cycles, ack 10 cycles later -> irq_out high for 10 cycles, strike_cnt=1, sys_rstn_out stays 1, reset_cause=00.
- Single edge with no ack -> irq_out high for 64 cycles, then sys_rstn_out low for exactly 16 cycles, reset_cause=01, strike_cnt=0 after the pulse.
- Three edges, each acknowledged -> third edge goes straight to RESET with no irq, reset_cause=10, 16-cycle pulse.
- ack and window expiry in the same cycle (ack on cycle 64) -> return to IDLE, no reset.
- Second edge in PENDING plus ack in the same cycle -> strike_cnt=2, IDLE, irq_out drops.
- rstn asserted mid-RESET (cycle 5 of 16) -> sys_rstn_out=1 and all outputs at reset values immediately. wdt_intr high at release -> counted as strike 1, irq_out high 1 cycle later.
